// File: rtl/argmax_classifier.sv
// argmax_classifier: snapshots a signed score vector, scans it one element per
// cycle for the best and second-best scores, then presents the winning index,
// its score, the best-minus-second margin and an uncertainty flag.
// Element i of in_scores occupies bits [i*SCORE_W +: SCORE_W].
module argmax_classifier #(
    parameter int                 N_CLASSES  = 3,
    parameter int                 SCORE_W    = 32,
    parameter logic [SCORE_W:0]   MIN_MARGIN = '0,
    localparam int                IDX_W      = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CLASSES*SCORE_W-1:0]   in_scores,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [IDX_W-1:0]               out_idx,
    output logic signed [SCORE_W-1:0]      out_score,
    output logic [SCORE_W:0]               out_margin,
    output logic                           out_uncertain,
    output logic                           out_valid,
    input  logic                           out_ready
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W:0]          MAX_MARGIN = {1'b0, {SCORE_W{1'b1}}};

    state_t state, next_state;

    logic signed [SCORE_W-1:0] snap [N_CLASSES];
    logic [IDX_W-1:0]          scan_idx;
    logic signed [SCORE_W-1:0] best, second;
    logic [IDX_W-1:0]          best_idx;

    logic signed [SCORE_W-1:0] cur, nxt_best, nxt_second;
    logic [IDX_W-1:0]          nxt_idx;
    logic [SCORE_W:0]          nxt_margin;
    logic                      nxt_uncertain;
    logic                      last;

    // rst gates in_ready so nothing is accepted on the reset edge itself
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign last      = (scan_idx == IDX_W'(N_CLASSES - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = SCAN;
            SCAN:    if (last)                 next_state = DONE;
            DONE:    if (out_ready)            next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // one scan step: fold the current element into the running best/second
    always_comb begin
        cur = snap[0];
        for (int i = 0; i < N_CLASSES; i++)
            if (scan_idx == IDX_W'(i)) cur = snap[i];
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (scan_idx == '0) begin
            nxt_best   = cur;
            nxt_idx    = '0;
            nxt_second = MOST_NEG;
        end else if (cur > best) begin
            nxt_second = best;
            nxt_best   = cur;
            nxt_idx    = scan_idx;
        end else if (cur > second) begin
            nxt_second = cur;
        end
        // sign-extend both operands so the difference can never overflow
        nxt_margin    = {nxt_best[SCORE_W-1], nxt_best} - {nxt_second[SCORE_W-1], nxt_second};
        nxt_uncertain = (nxt_margin < MIN_MARGIN);
        if (N_CLASSES == 1) begin
            nxt_margin    = MAX_MARGIN;
            nxt_uncertain = 1'b0;
        end
    end

    // snapshot capture, scan registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx      <= '0;
            best          <= '0;
            second        <= '0;
            best_idx      <= '0;
            out_idx       <= '0;
            out_score     <= '0;
            out_margin    <= '0;
            out_uncertain <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_CLASSES; i++)
                            snap[i] <= in_scores[i*SCORE_W +: SCORE_W];
                        scan_idx <= '0;
                    end
                end
                SCAN: begin
                    best     <= nxt_best;
                    second   <= nxt_second;
                    best_idx <= nxt_idx;
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (last) begin
                        out_idx       <= nxt_idx;
                        out_score     <= nxt_best;
                        out_margin    <= nxt_margin;
                        out_uncertain <= nxt_uncertain;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed cases plus randomized
// vectors compared against an array-based argmax reference model.
module tb_argmax_classifier;

    localparam int         N  = 3;
    localparam int         W  = 32;
    localparam logic [W:0] MM = 33'd16;
    localparam int         IW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*W-1:0]       in_scores;
    logic                 in_valid;
    logic                 in_ready;
    logic [IW-1:0]        out_idx;
    logic signed [W-1:0]  out_score;
    logic [W:0]           out_margin;
    logic                 out_uncertain;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    argmax_classifier #(.N_CLASSES(N), .SCORE_W(W), .MIN_MARGIN(MM)) dut (
        .clk(clk), .rst(rst), .in_scores(in_scores), .in_valid(in_valid),
        .in_ready(in_ready), .out_idx(out_idx), .out_score(out_score),
        .out_margin(out_margin), .out_uncertain(out_uncertain),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: lowest-index maximum, second = max of the remaining elements
    function automatic void model(input int s[N], output int idx, output int best,
                                  output longint margin, output bit unc);
        int second;
        idx = 0;
        for (int i = 1; i < N; i++)
            if (s[i] > s[idx]) idx = i;
        best = s[idx];
        if (N == 1) begin
            margin = (longint'(1) <<< W) - 1;
            unc    = 1'b0;
        end else begin
            second = int'(32'h8000_0000);
            for (int i = 0; i < N; i++)
                if (i != idx && s[i] > second) second = s[i];
            margin = longint'(best) - longint'(second);
            unc    = (margin < longint'(MM));
        end
    endfunction

    task automatic load(input int s[N]);
        for (int i = 0; i < N; i++) in_scores[i*W +: W] = s[i];
    endtask

    task automatic run_vec(input int s[N], input int stall, input bit use_alt, input int alt[N]);
        int     e_idx, e_score, lat, waitc;
        longint e_margin;
        bit     e_unc;
        model(s, e_idx, e_score, e_margin, e_unc);
        waitc = 0;
        while (!in_ready && waitc < 50) begin tick(); waitc++; end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        load(s);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (use_alt) load(alt);
        else for (int i = 0; i < N; i++) in_scores[i*W +: W] = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_scan", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        check("idx", 64'(out_idx), 64'(e_idx));
        check("score", 64'(out_score), 64'(e_score));
        check("margin", 64'(out_margin), 64'(e_margin));
        check("uncertain", 64'(out_uncertain), 64'(e_unc));
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) in_scores[i*W +: W] = $urandom;
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_idx", 64'(out_idx), 64'(e_idx));
            check("stall_score", 64'(out_score), 64'(e_score));
            check("stall_margin", 64'(out_margin), 64'(e_margin));
            check("stall_unc", 64'(out_uncertain), 64'(e_unc));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_idx", 64'(out_idx), 64'(e_idx));
        check("post_margin", 64'(out_margin), 64'(e_margin));
    endtask

    initial begin
        int v[N];
        int alt[N];
        int mode;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_scores = '0;
        alt       = '{999, 0, 0};
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_score", 64'(out_score), 64'd0);
        check("rst_margin", 64'(out_margin), 64'd0);
        check("rst_unc", 64'(out_uncertain), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_release_ready", 64'(in_ready), 64'd1);

        v = '{100, -50, 300};                 run_vec(v, 0, 1'b0, alt);
        v = '{7, 7, -1};                      run_vec(v, 0, 1'b0, alt);
        v = '{int'(32'h8000_0000), 32'h7fff_ffff, int'(32'h8000_0000)};
        run_vec(v, 0, 1'b0, alt);
        v = '{-5, -9, -1};                    run_vec(v, 10, 1'b0, alt);
        v = '{0, 0, 5};                       run_vec(v, 0, 1'b1, alt);

        // abort in the second scan cycle
        v = '{4, 8, 1};
        load(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_idx", 64'(out_idx), 64'd0);
        check("abort_score", 64'(out_score), 64'd0);
        check("abort_margin", 64'(out_margin), 64'd0);
        tick();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_still_idle", 64'(out_valid), 64'd0);
        v = '{1, 2, 3};                       run_vec(v, 0, 1'b0, alt);

        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 1));
            for (int i = 0; i < N; i++)
                v[i] = mode ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
            run_vec(v, int'($urandom_range(0, 3)), 1'b0, alt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
